// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared state encoding, parameter defaults and width helper for the frame sequencer
package kalman_pkg;

    localparam int DEF_NUM_SENSORS = 3;
    localparam int DEF_NUM_AXES    = 3;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FILTER,
        S_WRITE,
        S_XMIT,
        S_WAIT_PERIOD
    } seq_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - clearable saturating up-counter with a count >= limit flag
module seq_timer
    import kalman_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             reached_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturating so a long stall keeps the flag asserted instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign reached_o = (count_q >= limit_i);

endmodule

// File: rtl/kalman_frame_sequencer.sv
// rtl/kalman_frame_sequencer.sv - sensor read / filter / axis output frame sequencer
module kalman_frame_sequencer
    import kalman_pkg::*;
#(
    parameter  int NUM_SENSORS = DEF_NUM_SENSORS,
    parameter  int NUM_AXES    = DEF_NUM_AXES,
    parameter  int CNT_W       = DEF_CNT_W,
    localparam int SEL_W       = sel_width(NUM_AXES)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   configured_in,
    input  logic                   start_in,
    input  logic                   continuous_in,
    input  logic [CNT_W-1:0]       period_in,
    input  logic [CNT_W-1:0]       timeout_in,
    input  logic [NUM_SENSORS-1:0] sensor_ready_in,
    output logic [NUM_SENSORS-1:0] sensor_read_out,
    output logic [NUM_SENSORS-1:0] sensor_load_out,
    output logic                   filter_start_out,
    input  logic                   filter_done_in,
    output logic                   write_enable_out,
    output logic [SEL_W-1:0]       output_sel_out,
    input  logic                   output_done_in,
    output logic                   busy_out,
    output logic [15:0]            frame_count_out,
    output logic [NUM_SENSORS-1:0] timeout_err_out,
    output logic                   overrun_out
);

    localparam int IDX_W = sel_width(NUM_SENSORS);

    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SEL_W-1:0]       axis_q, axis_d;
    logic [NUM_SENSORS-1:0] load_q, load_d;
    logic [NUM_SENSORS-1:0] terr_q, terr_d;
    logic                   fstart_q, fstart_d;
    logic                   ovr_q, ovr_d;
    logic [15:0]            frame_q, frame_d;
    logic                   per_late_q;

    logic                   tmo_clear, per_clear;
    logic                   tmo_reached, per_reached;
    logic [CNT_W-1:0]       tmo_limit, per_limit;
    logic                   ready_now, tmo_hit;

    // Both timers flag on the cycle whose count equals limit-1, so a wait of N cycles ends after N cycles.
    assign tmo_limit = timeout_in - CNT_W'(1);
    assign per_limit = (period_in == '0) ? '0 : period_in - CNT_W'(1);
    assign ready_now = sensor_ready_in[idx_q];
    assign tmo_hit   = (timeout_in != '0) && tmo_reached;

    seq_timer #(.CNT_W(CNT_W)) u_tmo_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (tmo_clear),
        .limit_i   (tmo_limit),
        .reached_o (tmo_reached)
    );

    seq_timer #(.CNT_W(CNT_W)) u_per_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (per_clear),
        .limit_i   (per_limit),
        .reached_o (per_reached)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        axis_d    = axis_q;
        load_d    = '0;
        fstart_d  = 1'b0;
        frame_d   = frame_q;
        terr_d    = terr_q;
        ovr_d     = ovr_q;
        per_clear = 1'b0;
        tmo_clear = (state_q != S_REQ);
        if (!configured_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in || continuous_in) begin
                        state_d   = S_REQ;
                        idx_d     = '0;
                        per_clear = 1'b1;
                    end
                end
                S_REQ: begin
                    if (ready_now || tmo_hit) begin
                        tmo_clear = 1'b1;
                        if (ready_now) begin
                            load_d[idx_q] = 1'b1;
                        end else begin
                            terr_d[idx_q] = 1'b1;
                        end
                        if (idx_q == IDX_W'(NUM_SENSORS - 1)) begin
                            state_d  = S_FILTER;
                            fstart_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_FILTER: begin
                    if (filter_done_in) begin
                        state_d = S_WRITE;
                        axis_d  = '0;
                    end
                end
                S_WRITE: state_d = S_XMIT;
                S_XMIT: begin
                    if (output_done_in) begin
                        if (axis_q != SEL_W'(NUM_AXES - 1)) begin
                            axis_d  = axis_q + SEL_W'(1);
                            state_d = S_WRITE;
                        end else begin
                            frame_d = frame_q + 16'd1;
                            if (!continuous_in) begin
                                state_d = S_IDLE;
                            end else if (per_reached) begin
                                // Reached a cycle early is on time; reached before that means the frame ran long.
                                state_d   = S_REQ;
                                idx_d     = '0;
                                per_clear = 1'b1;
                                ovr_d     = ovr_q | per_late_q;
                            end else begin
                                state_d = S_WAIT_PERIOD;
                            end
                        end
                    end
                end
                S_WAIT_PERIOD: begin
                    if (!continuous_in) begin
                        state_d = S_IDLE;
                    end else if (per_reached) begin
                        state_d   = S_REQ;
                        idx_d     = '0;
                        per_clear = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            idx_q      <= '0;
            axis_q     <= '0;
            load_q     <= '0;
            terr_q     <= '0;
            fstart_q   <= 1'b0;
            ovr_q      <= 1'b0;
            frame_q    <= '0;
            per_late_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            axis_q     <= axis_d;
            load_q     <= load_d;
            terr_q     <= terr_d;
            fstart_q   <= fstart_d;
            ovr_q      <= ovr_d;
            frame_q    <= frame_d;
            per_late_q <= per_clear ? 1'b0 : per_reached;
        end
    end

    always_comb begin
        sensor_read_out  = '0;
        write_enable_out = 1'b0;
        busy_out         = (state_q != S_IDLE);
        if (state_q == S_REQ) begin
            sensor_read_out = NUM_SENSORS'(1) << idx_q;
        end
        if (state_q == S_WRITE) begin
            write_enable_out = 1'b1;
        end
    end

    assign sensor_load_out  = load_q;
    assign filter_start_out = fstart_q;
    assign output_sel_out   = axis_q;
    assign frame_count_out  = frame_q;
    assign timeout_err_out  = terr_q;
    assign overrun_out      = ovr_q;

endmodule

// File: tb/tb_kalman_frame_sequencer.sv
// tb/tb_kalman_frame_sequencer.sv - randomized self-checking bench for kalman_frame_sequencer
module tb_kalman_frame_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cfg_a, cfg_b, start, cont;
    logic [15:0] period, tmo;
    logic [7:0]  ready = '0;
    logic        fdone = 1'b0, odone = 1'b0;
    bit          cur = 1'b0;

    logic [2:0]  a_read, a_load, a_terr;
    logic        a_fs, a_we, a_busy, a_ovr;
    logic [1:0]  a_sel;
    logic [15:0] a_fc;
    logic [4:0]  b_read, b_load, b_terr;
    logic        b_fs, b_we, b_busy, b_ovr;
    logic [0:0]  b_sel;
    logic [15:0] b_fc;

    logic [7:0]  mread, mload, mterr;
    logic [2:0]  msel;
    logic        mfs, mwe, mbusy, movr;
    logic [15:0] mfc;

    always #5 clk = ~clk;

    kalman_frame_sequencer dut_a (
        .clk(clk), .n_rst(n_rst), .configured_in(cfg_a), .start_in(start),
        .continuous_in(cont), .period_in(period), .timeout_in(tmo),
        .sensor_ready_in(ready[2:0]), .sensor_read_out(a_read), .sensor_load_out(a_load),
        .filter_start_out(a_fs), .filter_done_in(fdone), .write_enable_out(a_we),
        .output_sel_out(a_sel), .output_done_in(odone), .busy_out(a_busy),
        .frame_count_out(a_fc), .timeout_err_out(a_terr), .overrun_out(a_ovr)
    );

    kalman_frame_sequencer #(.NUM_SENSORS(5), .NUM_AXES(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .configured_in(cfg_b), .start_in(start),
        .continuous_in(cont), .period_in(period), .timeout_in(tmo),
        .sensor_ready_in(ready[4:0]), .sensor_read_out(b_read), .sensor_load_out(b_load),
        .filter_start_out(b_fs), .filter_done_in(fdone), .write_enable_out(b_we),
        .output_sel_out(b_sel), .output_done_in(odone), .busy_out(b_busy),
        .frame_count_out(b_fc), .timeout_err_out(b_terr), .overrun_out(b_ovr)
    );

    assign mread = cur ? {3'b0, b_read} : {5'b0, a_read};
    assign mload = cur ? {3'b0, b_load} : {5'b0, a_load};
    assign mterr = cur ? {3'b0, b_terr} : {5'b0, a_terr};
    assign msel  = cur ? {2'b0, b_sel}  : {1'b0, a_sel};
    assign mfs   = cur ? b_fs   : a_fs;
    assign mwe   = cur ? b_we   : a_we;
    assign mbusy = cur ? b_busy : a_busy;
    assign movr  = cur ? b_ovr  : a_ovr;
    assign mfc   = cur ? b_fc   : a_fc;

    int     d[8];
    int     fd, od;
    int     rcnt[8], rdur[8];
    int     fcnt, ocnt, fs_cnt;
    bit     fact, oact, prev_r0;
    int     load_q[$], sel_q[$];
    longint req_q[$];
    longint cyc = 0;
    int     n_checks = 0, n_pass = 0;
    int     fc_exp;
    logic [7:0] terr_exp;

    always @(posedge clk) cyc <= cyc + 1;

    // Sensor, filter and output-link responders plus event recorder, all acting on the falling edge.
    initial begin
        fcnt = 0; ocnt = 0; fs_cnt = 0; fact = 0; oact = 0; prev_r0 = 0;
        for (int i = 0; i < 8; i++) begin rcnt[i] = 0; rdur[i] = 0; end
        forever begin
            @(negedge clk);
            if (!mbusy) begin fact = 0; oact = 0; end
            for (int i = 0; i < 8; i++) begin
                ready[i] = mread[i] && (rcnt[i] == d[i]);
                if (mread[i]) begin rcnt[i]++; rdur[i] = rcnt[i]; end
                else rcnt[i] = 0;
                if (mload[i]) load_q.push_back(i);
            end
            if (mread[0] && !prev_r0) req_q.push_back(cyc);
            prev_r0 = mread[0];
            if (mfs) begin fs_cnt++; fact = 1; fcnt = 0; end
            fdone = fact && (fcnt == fd);
            if (fdone) fact = 0;
            fcnt++;
            if (mwe) begin sel_q.push_back(int'(msel)); oact = 1; ocnt = 0; end
            odone = oact && (ocnt == od);
            if (odone) oact = 0;
            ocnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        fc_exp = 0;
        terr_exp = '0;
        @(negedge clk);
    endtask

    task automatic clear_sb();
        load_q.delete();
        sel_q.delete();
        req_q.delete();
        fs_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int n = 0; n < budget && mbusy; n++) @(negedge clk);
        check_eq({tag, "_idle"}, mbusy, 0);
    endtask

    function automatic bit sensor_ok(input int i);
        return (tmo == 0) || (d[i] < int'(tmo));
    endfunction

    task automatic run_oneshot(input string tag, input int ns, input int na);
        int exp_loads[$];
        clear_sb();
        pulse_start();
        wait_idle(tag, 4000);
        @(negedge clk);
        for (int i = 0; i < ns; i++) begin
            if (sensor_ok(i)) exp_loads.push_back(i);
            else terr_exp[i] = 1'b1;
            check_eq($sformatf("%s_rdur%0d", tag, i), rdur[i], sensor_ok(i) ? d[i] + 1 : int'(tmo));
        end
        check_eq({tag, "_nload"}, load_q.size(), exp_loads.size());
        for (int i = 0; i < exp_loads.size(); i++)
            check_eq($sformatf("%s_load%0d", tag, i), (i < load_q.size()) ? load_q[i] : 99, exp_loads[i]);
        check_eq({tag, "_fstart"}, fs_cnt, 1);
        check_eq({tag, "_nwrite"}, sel_q.size(), na);
        for (int i = 0; i < na; i++)
            check_eq($sformatf("%s_sel%0d", tag, i), (i < sel_q.size()) ? sel_q[i] : 99, i);
        fc_exp++;
        check_eq({tag, "_fc"}, mfc, fc_exp);
        check_eq({tag, "_terr"}, mterr, terr_exp);
    endtask

    task automatic run_cont(input string tag, input int ns, input int na, input int nent);
        int len, exp_iv;
        len = fd + 1 + na * (1 + od);
        for (int i = 0; i < ns; i++) len += sensor_ok(i) ? d[i] + 1 : int'(tmo);
        exp_iv = (len > int'(period)) ? len : int'(period);
        clear_sb();
        cont = 1'b1;
        for (int n = 0; n < nent * exp_iv + 200 && req_q.size() < nent; n++) @(negedge clk);
        check_eq({tag, "_entries"}, req_q.size() >= nent, 1);
        for (int k = 1; k < nent; k++)
            check_eq($sformatf("%s_iv%0d", tag, k),
                     (k < req_q.size()) ? req_q[k] - req_q[k-1] : -1, exp_iv);
        check_eq({tag, "_ovr"}, movr, len > int'(period));
        cont = 1'b0;
        wait_idle(tag, exp_iv + 300);
    endtask

    initial begin
        n_rst = 1'b0; cfg_a = 1'b0; cfg_b = 1'b0; start = 1'b0; cont = 1'b0;
        period = '0; tmo = '0; fd = 0; od = 1;
        for (int i = 0; i < 8; i++) d[i] = 0;
        do_reset();
        check_eq("rst_busy", mbusy, 0);
        check_eq("rst_read", mread, 0);
        check_eq("rst_load", mload, 0);
        check_eq("rst_we", mwe, 0);
        check_eq("rst_sel", msel, 0);
        check_eq("rst_fc", mfc, 0);
        check_eq("rst_terr", mterr, 0);
        check_eq("rst_ovr", movr, 0);

        cfg_a = 1'b1;
        d[0] = 5; d[1] = 7; d[2] = 9;
        fd = $urandom_range(0, 10); od = $urandom_range(1, 4);
        run_oneshot("basic", 3, 3);

        tmo = 10; d[0] = 2; d[1] = 50; d[2] = 3;
        run_oneshot("tmo", 3, 3);
        check_eq("tmo_err010", mterr, 8'b010);

        do_reset();
        for (int f = 0; f < 4; f++) begin
            tmo = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 10));
            for (int i = 0; i < 3; i++) d[i] = $urandom_range(0, 12);
            fd = $urandom_range(0, 20); od = $urandom_range(1, 5);
            run_oneshot($sformatf("rnd%0d", f), 3, 3);
        end

        tmo = 0;
        for (int i = 0; i < 3; i++) d[i] = 30;
        clear_sb();
        pulse_start();
        repeat (4) @(negedge clk);
        check_eq("rstreq_pre_busy", mbusy, 1);
        n_rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rstreq_read", mread, 0);
        check_eq("rstreq_busy", mbusy, 0);
        check_eq("rstreq_fc", mfc, 0);
        check_eq("rstreq_terr", mterr, 0);
        check_eq("rstreq_ovr", movr, 0);
        @(negedge clk);
        n_rst = 1'b1;
        fc_exp = 0; terr_exp = '0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) d[i] = 1;
        fd = 2; od = 4;
        run_oneshot("cfgpre", 3, 3);
        clear_sb();
        pulse_start();
        for (int n = 0; n < 500 && !(mwe && msel == 3'd1); n++) @(negedge clk);
        check_eq("cfg_found_axis1", mwe && msel == 3'd1, 1);
        @(negedge clk);
        cfg_a = 1'b0;
        @(posedge clk); #1;
        check_eq("cfg_busy", mbusy, 0);
        check_eq("cfg_read", mread, 0);
        check_eq("cfg_we", mwe, 0);
        check_eq("cfg_load", mload, 0);
        check_eq("cfg_fs", mfs, 0);
        check_eq("cfg_fc", mfc, fc_exp);
        check_eq("cfg_sel_hold", msel, 1);
        @(negedge clk);
        cfg_a = 1'b1;

        do_reset();
        for (int i = 0; i < 3; i++) d[i] = 0;
        fd = 0; od = 1; period = 200;
        run_cont("per200", 3, 3, 4);

        period = $urandom_range(20, 80);
        for (int i = 0; i < 3; i++) d[i] = $urandom_range(0, 8);
        fd = $urandom_range(0, 40); od = $urandom_range(1, 4);
        run_cont("rndper", 3, 3, 3);

        do_reset();
        for (int i = 0; i < 3; i++) d[i] = 0;
        period = 20; fd = 50; od = 2;
        run_cont("ovr", 3, 3, 3);

        cfg_a = 1'b0; cfg_b = 1'b1; cur = 1'b1;
        do_reset();
        tmo = 6;
        for (int i = 0; i < 5; i++) d[i] = i + 1;
        fd = 3; od = 2;
        run_oneshot("b5", 5, 2);
        tmo = 16'($urandom_range(2, 8));
        for (int i = 0; i < 5; i++) d[i] = $urandom_range(0, 9);
        fd = $urandom_range(0, 10); od = $urandom_range(1, 3);
        run_oneshot("b5rnd", 5, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
